ram_vector_add_engine: RTL

//  Bus master for RAM_DUAL_READ_PORT: streams Ram[iSrcA+k] + Ram[iSrcB+k] into Ram[iDst+k] for k=0..iLength-1.

---
 rtl/ram_vector_add_engine_pkg.sv | 15 +
 rtl/ram_addr_gen.sv | 32 +++
 rtl/ram_vector_add_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_vector_add_engine_pkg.sv
// Shared definitions for the RAM vector-add engine: FSM state encodings
// and the length-width derivation used by the top-level parameter list.
package ram_vector_add_engine_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // One extra bit so a full 2^ADDR_WIDTH-element run is representable.
    function automatic int unsigned len_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_addr_gen.sv
// Address generator: latches a base address on load and produces
// base + element offset (mod 2^ADDR_WIDTH), advancing the offset on step.
module ram_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  iLoad,
    input  logic                  iStep,
    input  logic [ADDR_WIDTH-1:0] iBase,
    output logic [ADDR_WIDTH-1:0] oAddress
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] offset_q;

    // Base/offset registers: load restarts the offset at zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            base_q   <= '0;
            offset_q <= '0;
        end else if (iLoad) begin
            base_q   <= iBase;
            offset_q <= '0;
        end else if (iStep) begin
            offset_q <= offset_q + ADDR_WIDTH'(1);
        end
    end

    assign oAddress = base_q + offset_q;

endmodule

// File: rtl/ram_vector_add_engine.sv
// RAM vector-add engine: streams Ram[srcA+k] + Ram[srcB+k] into Ram[dst+k]
// using both registered read ports and the write port of a dual-read RAM.
module ram_vector_add_engine
    import ram_vector_add_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iSrcA,
    input  logic [ADDR_WIDTH-1:0] iSrcB,
    input  logic [ADDR_WIDTH-1:0] iDst,
    input  logic [LEN_WIDTH-1:0]  iLength,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOverflow,
    output logic [ADDR_WIDTH-1:0] oRamReadAddress0,
    output logic [ADDR_WIDTH-1:0] oRamReadAddress1,
    output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
    output logic                  oRamWriteEnable,
    output logic [DATA_WIDTH-1:0] oRamDataIn,
    input  logic [DATA_WIDTH-1:0] iRamDataOut0,
    input  logic [DATA_WIDTH-1:0] iRamDataOut1
);

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] remain_q, remain_d;
    logic                 overflow_q, overflow_d;

    logic                 start_accept;
    logic                 in_prime;
    logic                 in_stream;
    logic [DATA_WIDTH:0]  sum;

    assign start_accept = (state_q == ST_IDLE) && iStart;
    assign in_prime     = (state_q == ST_PRIME);
    assign in_stream    = (state_q == ST_STREAM);
    assign sum          = {1'b0, iRamDataOut0} + {1'b0, iRamDataOut1};

    // Read generators run one element ahead of the write generator: they
    // step in PRIME as well, so during STREAM element k they fetch k+1.
    ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_src_a (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .iLoad    (start_accept),
        .iStep    (in_prime || in_stream),
        .iBase    (iSrcA),
        .oAddress (oRamReadAddress0)
    );

    ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_src_b (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .iLoad    (start_accept),
        .iStep    (in_prime || in_stream),
        .iBase    (iSrcB),
        .oAddress (oRamReadAddress1)
    );

    ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen_dst (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .iLoad    (start_accept),
        .iStep    (in_stream),
        .iBase    (iDst),
        .oAddress (oRamWriteAddress)
    );

    // Next-state logic for the FSM, remaining count and sticky overflow.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    remain_d   = iLength;
                    overflow_d = 1'b0;
                    state_d    = (iLength == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                remain_d = remain_q - LEN_WIDTH'(1);
                if (sum[DATA_WIDTH]) begin
                    overflow_d = 1'b1;
                end
                if (remain_q == LEN_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run without a done pulse.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            overflow_q <= overflow_d;
        end
    end

    assign oBusy           = in_prime || in_stream;
    assign oDone           = (state_q == ST_DONE);
    assign oOverflow       = overflow_q;
    assign oRamWriteEnable = in_stream;
    assign oRamDataIn      = in_stream ? sum[DATA_WIDTH-1:0] : '0;

endmodule
